// File: rtl/soc_sram_responder.sv
// SRAM-port responder: word RAM with byte enables (read-first, 1-cycle latency) plus an
// optional MMIO window (scratch/timer/wcount/led) present when SOC_SRAM_RESP_MMIO_EN is defined.
module soc_sram_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WE_W   = 4;
    localparam int unsigned LED_W  = 16;
    localparam int unsigned OFF_W  = 14;
    localparam int unsigned DEPTH  = 32'd1 << ADDR_W;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [WE_W-1:0]   we
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(WE_W); i++) begin
            if (we[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] ram_rd_word;
    logic [DATA_W-1:0] mmio_rd_word;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              is_mmio;
    logic              ram_wr;
    logic              unused_bits;

    assign word_idx    = sram_addr[ADDR_W+1:2];
    assign ram_rd_word = mem_q[word_idx];
    assign ram_wr      = sram_en & ~is_mmio & (sram_we != WE_W'(0));

    // Writes are blocked while reset is held so an access overlapping reset is not taken.
    always_ff @(posedge clk) begin
        if (!reset && ram_wr) begin
            mem_q[word_idx] <= byte_merge(ram_rd_word, sram_wdata, sram_we);
        end
    end

`ifdef SOC_SRAM_RESP_MMIO_EN
    localparam logic [OFF_W-1:0] OFF_SCRATCH = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_TIMER   = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_WCOUNT  = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_LED     = OFF_W'(3);

    logic [DATA_W-1:0] scratch_d, scratch_q;
    logic [DATA_W-1:0] timer_d, timer_q;
    logic [DATA_W-1:0] wcount_d, wcount_q;
    logic [LED_W-1:0]  led_d, led_q;
    logic [OFF_W-1:0]  mmio_off;
    logic              mmio_wr;

    assign is_mmio     = (sram_addr[31:16] == MMIO_BASE[31:16]);
    assign mmio_off    = sram_addr[15:2];
    assign mmio_wr     = sram_en & is_mmio & (sram_we != WE_W'(0));
    assign unused_bits = ^sram_addr[1:0];

    // Register-file read mux and next-state; a timer write replaces that cycle's increment.
    always_comb begin
        scratch_d    = scratch_q;
        timer_d      = timer_q + DATA_W'(1);
        wcount_d     = wcount_q;
        led_d        = led_q;
        mmio_rd_word = '0;

        if (ram_wr && (wcount_q != '1)) begin
            wcount_d = wcount_q + DATA_W'(1);
        end

        case (mmio_off)
            OFF_SCRATCH: mmio_rd_word = scratch_q;
            OFF_TIMER:   mmio_rd_word = timer_q;
            OFF_WCOUNT:  mmio_rd_word = wcount_q;
            OFF_LED:     mmio_rd_word = {{(DATA_W-LED_W){1'b0}}, led_q};
            default:     mmio_rd_word = '0;
        endcase

        if (mmio_wr) begin
            case (mmio_off)
                OFF_SCRATCH: scratch_d = byte_merge(scratch_q, sram_wdata, sram_we);
                OFF_TIMER:   timer_d   = byte_merge(timer_q, sram_wdata, sram_we);
                OFF_LED: begin
                    if (sram_we[0]) led_d[7:0]  = sram_wdata[7:0];
                    if (sram_we[1]) led_d[15:8] = sram_wdata[15:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch_q <= '0;
            timer_q   <= '0;
            wcount_q  <= '0;
            led_q     <= '0;
        end else begin
            scratch_q <= scratch_d;
            timer_q   <= timer_d;
            wcount_q  <= wcount_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;
`else
    // Without the window every address, including the MMIO page, aliases into RAM.
    assign is_mmio      = 1'b0;
    assign mmio_rd_word = '0;
    assign led          = '0;
    assign unused_bits  = ^{sram_addr[31:ADDR_W+2], sram_addr[1:0], MMIO_BASE};
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (sram_en) begin
            rdata_d = is_mmio ? mmio_rd_word : ram_rd_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign sram_rdata = rdata_q;

endmodule
